// File: rtl/control_pipeline.sv
// rtl/control_pipeline.sv - pipelined RISC-V control unit with flush, bubbles and a bubble counter
// Decodes in ID and carries per-stage copies of the control bits through ID/EX, EX/MEM and MEM/WB.
module control_pipeline #(
  parameter int ALUOP_W   = 2,
  parameter bit ENABLE_UJ = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [6:0]         opcode,
  input  logic               stall,
  input  logic               flush,
  input  logic               cnt_clr,
  output logic               ex_valid,
  output logic               ex_alusrc,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_illegal,
  output logic [1:0]         ex_asel,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               mem_valid,
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic               mem_branch,
  output logic               mem_jump,
  output logic               wb_valid,
  output logic               wb_regwrite,
  output logic [1:0]         wb_sel,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_BR  = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_I   = ALUOP_W'(2'b11);

  localparam logic [1:0] ASEL_PC   = 2'b01;
  localparam logic [1:0] ASEL_ZERO = 2'b10;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic               valid;
    logic               alusrc;
    logic               branch;
    logic               jump;
    logic               illegal;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic [1:0]         asel;
    logic [1:0]         wb_sel;
    logic [ALUOP_W-1:0] aluop;
  } id_ex_t;

  typedef struct packed {
    logic       valid;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       regwrite;
    logic [1:0] wb_sel;
  } ex_mem_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] wb_sel;
  } mem_wb_t;

  id_ex_t     dec;
  id_ex_t     ex_d, ex_q;
  ex_mem_t    mem_d, mem_q;
  mem_wb_t    wb_d, wb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic       bubble;

  // An invalid slot decodes to all zero, so illegal only fires for real instructions.
  always_comb begin
    dec = '0;
    if (id_valid) begin
      dec.valid = 1'b1;
      case (opcode)
        OP_LOAD: begin
          dec.alusrc   = 1'b1;
          dec.memread  = 1'b1;
          dec.regwrite = 1'b1;
          dec.wb_sel   = WB_MEM;
          dec.aluop    = ALU_ADD;
        end
        OP_STORE: begin
          dec.alusrc   = 1'b1;
          dec.memwrite = 1'b1;
          dec.aluop    = ALU_ADD;
        end
        OP_RTYPE: begin
          dec.regwrite = 1'b1;
          dec.aluop    = ALU_R;
        end
        OP_IALU: begin
          dec.alusrc   = 1'b1;
          dec.regwrite = 1'b1;
          dec.aluop    = ALU_I;
        end
        OP_BRANCH: begin
          dec.branch = 1'b1;
          dec.aluop  = ALU_BR;
        end
        OP_LUI: begin
          if (ENABLE_UJ) begin
            dec.asel     = ASEL_ZERO;
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.aluop    = ALU_ADD;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OP_AUIPC: begin
          if (ENABLE_UJ) begin
            dec.asel     = ASEL_PC;
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.aluop    = ALU_ADD;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OP_JAL: begin
          if (ENABLE_UJ) begin
            dec.jump     = 1'b1;
            dec.regwrite = 1'b1;
            dec.wb_sel   = WB_PC4;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OP_JALR: begin
          if (ENABLE_UJ) begin
            dec.jump     = 1'b1;
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.wb_sel   = WB_PC4;
            dec.aluop    = ALU_ADD;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // Flush outranks stall, but either one clears ID/EX the same way.
  assign bubble = id_valid & (stall | flush);

  always_comb begin
    ex_d = (flush | stall) ? '0 : dec;

    mem_d = '0;
    if (!flush) begin
      mem_d.valid    = ex_q.valid;
      mem_d.memread  = ex_q.memread;
      mem_d.memwrite = ex_q.memwrite;
      mem_d.branch   = ex_q.branch;
      mem_d.jump     = ex_q.jump;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.wb_sel   = ex_q.wb_sel;
    end

    // MEM/WB ignores flush: the branch that caused it sits in MEM and must commit.
    wb_d.valid    = mem_q.valid;
    wb_d.regwrite = mem_q.regwrite;
    wb_d.wb_sel   = mem_q.wb_sel;

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (bubble && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_branch    = ex_q.branch;
  assign ex_jump      = ex_q.jump;
  assign ex_illegal   = ex_q.illegal;
  assign ex_asel      = ex_q.asel;
  assign ex_aluop     = ex_q.aluop;
  assign mem_valid    = mem_q.valid;
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign mem_branch   = mem_q.branch;
  assign mem_jump     = mem_q.jump;
  assign wb_valid     = wb_q.valid;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_sel       = wb_q.wb_sel;
  assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// tb/tb_control_pipeline.sv - randomized bench for control_pipeline against a stage-list reference model
module tb_control_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_valid, stall, flush, cnt_clr;
  logic [6:0] opcode;

  // Build A: U/J enabled, 3-bit counter. Build B: U/J disabled, 3-bit aluop, 16-bit counter.
  logic a_ex_valid, a_ex_alusrc, a_ex_branch, a_ex_jump, a_ex_illegal;
  logic [1:0] a_ex_asel;
  logic [1:0] a_ex_aluop;
  logic a_mem_valid, a_mem_memread, a_mem_memwrite, a_mem_branch, a_mem_jump;
  logic a_wb_valid, a_wb_regwrite;
  logic [1:0] a_wb_sel;
  logic [2:0] a_bubble_cnt;

  logic b_ex_valid, b_ex_alusrc, b_ex_branch, b_ex_jump, b_ex_illegal;
  logic [1:0] b_ex_asel;
  logic [2:0] b_ex_aluop;
  logic b_mem_valid, b_mem_memread, b_mem_memwrite, b_mem_branch, b_mem_jump;
  logic b_wb_valid, b_wb_regwrite;
  logic [1:0] b_wb_sel;
  logic [15:0] b_bubble_cnt;

  control_pipeline #(.ALUOP_W(2), .ENABLE_UJ(1'b1), .CNT_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .stall(stall),
    .flush(flush), .cnt_clr(cnt_clr),
    .ex_valid(a_ex_valid), .ex_alusrc(a_ex_alusrc), .ex_branch(a_ex_branch),
    .ex_jump(a_ex_jump), .ex_illegal(a_ex_illegal), .ex_asel(a_ex_asel), .ex_aluop(a_ex_aluop),
    .mem_valid(a_mem_valid), .mem_memread(a_mem_memread), .mem_memwrite(a_mem_memwrite),
    .mem_branch(a_mem_branch), .mem_jump(a_mem_jump),
    .wb_valid(a_wb_valid), .wb_regwrite(a_wb_regwrite), .wb_sel(a_wb_sel),
    .bubble_cnt(a_bubble_cnt)
  );

  control_pipeline #(.ALUOP_W(3), .ENABLE_UJ(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .stall(stall),
    .flush(flush), .cnt_clr(cnt_clr),
    .ex_valid(b_ex_valid), .ex_alusrc(b_ex_alusrc), .ex_branch(b_ex_branch),
    .ex_jump(b_ex_jump), .ex_illegal(b_ex_illegal), .ex_asel(b_ex_asel), .ex_aluop(b_ex_aluop),
    .mem_valid(b_mem_valid), .mem_memread(b_mem_memread), .mem_memwrite(b_mem_memwrite),
    .mem_branch(b_mem_branch), .mem_jump(b_mem_jump),
    .wb_valid(b_wb_valid), .wb_regwrite(b_wb_regwrite), .wb_sel(b_wb_sel),
    .bubble_cnt(b_bubble_cnt)
  );

  typedef struct {
    bit       valid, alusrc, branch, jump, illegal, memread, memwrite, regwrite;
    bit [1:0] asel, wb_sel, aluop;
  } ctl_t;

  ctl_t m_ex[2], m_mem[2], m_wb[2];
  int   m_cnt[2];
  int   cnt_max[2] = '{7, 65535};
  bit   uj_en[2]   = '{1'b1, 1'b0};

  int n_total = 0;
  int n_pass  = 0;

  localparam bit [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYP = 7'b0110011;
  localparam bit [6:0] IALU = 7'b0010011, BRAN = 7'b1100011, LUI = 7'b0110111;
  localparam bit [6:0] AUIP = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  bit [6:0] ops[9] = '{LOAD, STORE, RTYP, IALU, BRAN, LUI, AUIP, JAL, JALR};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  function automatic ctl_t zero_ctl();
    ctl_t c;
    c = '{default: 0};
    return c;
  endfunction

  // Decode table written straight from the opcode list.
  function automatic ctl_t decode(bit v, bit [6:0] op, bit uj);
    ctl_t c = zero_ctl();
    if (!v) return c;
    c.valid = 1;
    case (op)
      LOAD:  begin c.alusrc = 1; c.memread = 1; c.regwrite = 1; c.wb_sel = 2'b01; end
      STORE: begin c.alusrc = 1; c.memwrite = 1; end
      RTYP:  begin c.regwrite = 1; c.aluop = 2'b10; end
      IALU:  begin c.alusrc = 1; c.regwrite = 1; c.aluop = 2'b11; end
      BRAN:  begin c.branch = 1; c.aluop = 2'b01; end
      LUI:   if (uj) begin c.asel = 2'b10; c.alusrc = 1; c.regwrite = 1; end else c.illegal = 1;
      AUIP:  if (uj) begin c.asel = 2'b01; c.alusrc = 1; c.regwrite = 1; end else c.illegal = 1;
      JAL:   if (uj) begin c.jump = 1; c.regwrite = 1; c.wb_sel = 2'b10; end else c.illegal = 1;
      JALR:  if (uj) begin c.jump = 1; c.alusrc = 1; c.regwrite = 1; c.wb_sel = 2'b10; end
             else c.illegal = 1;
      default: c.illegal = 1;
    endcase
    return c;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ex[d] = zero_ctl(); m_mem[d] = zero_ctl(); m_wb[d] = zero_ctl(); m_cnt[d] = 0;
    end
  endtask

  // One instruction slot per stage; the list shifts forward each edge.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_wb[d]  = m_mem[d];
      m_mem[d] = flush ? zero_ctl() : m_ex[d];
      m_ex[d]  = (flush || stall) ? zero_ctl() : decode(id_valid, opcode, uj_en[d]);
      if (cnt_clr) m_cnt[d] = 0;
      else if (id_valid && (stall || flush) && m_cnt[d] < cnt_max[d]) m_cnt[d]++;
    end
  endtask

  task automatic compare_all();
    ctl_t e, m, w;
    e = m_ex[0]; m = m_mem[0]; w = m_wb[0];
    check("a_ex", {a_ex_valid, a_ex_alusrc, a_ex_branch, a_ex_jump, a_ex_illegal, a_ex_asel},
          {e.valid, e.alusrc, e.branch, e.jump, e.illegal, e.asel});
    check("a_aluop", 32'(a_ex_aluop), 32'(e.aluop));
    check("a_mem", {a_mem_valid, a_mem_memread, a_mem_memwrite, a_mem_branch, a_mem_jump},
          {m.valid, m.memread, m.memwrite, m.branch, m.jump});
    check("a_wb", {a_wb_valid, a_wb_regwrite, a_wb_sel}, {w.valid, w.regwrite, w.wb_sel});
    check("a_cnt", 32'(a_bubble_cnt), 32'(m_cnt[0]));
    e = m_ex[1]; m = m_mem[1]; w = m_wb[1];
    check("b_ex", {b_ex_valid, b_ex_alusrc, b_ex_branch, b_ex_jump, b_ex_illegal, b_ex_asel},
          {e.valid, e.alusrc, e.branch, e.jump, e.illegal, e.asel});
    check("b_aluop", 32'(b_ex_aluop), 32'(e.aluop));
    check("b_mem", {b_mem_valid, b_mem_memread, b_mem_memwrite, b_mem_branch, b_mem_jump},
          {m.valid, m.memread, m.memwrite, m.branch, m.jump});
    check("b_wb", {b_wb_valid, b_wb_regwrite, b_wb_sel}, {w.valid, w.regwrite, w.wb_sel});
    check("b_cnt", 32'(b_bubble_cnt), 32'(m_cnt[1]));
  endtask

  task automatic cyc(input bit v, input bit [6:0] op, input bit st, input bit fl, input bit clr);
    id_valid = v; opcode = op; stall = st; flush = fl; cnt_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    bit [6:0] op;
    rst_n = 1'b0; id_valid = 0; opcode = '0; stall = 0; flush = 0; cnt_clr = 0;
    model_reset();
    @(posedge clk); #1;
    compare_all();
    @(negedge clk); rst_n = 1'b1;
    #4;

    // Basic stream, then LOAD with a stalled dependent R-type.
    foreach (ops[i]) cyc(1, ops[i], 0, 0, 0);
    cyc(1, LOAD, 0, 0, 0);
    cyc(1, RTYP, 1, 0, 0);
    cyc(1, RTYP, 0, 0, 0);
    // BRANCH reaches MEM while JAL is in ID: flush.
    cyc(1, BRAN, 0, 0, 0);
    cyc(1, IALU, 0, 0, 0);
    cyc(1, JAL, 0, 1, 0);
    cyc(1, JAL, 0, 1, 1);
    cyc(0, 7'h00, 0, 0, 0);
    cyc(0, 7'h00, 0, 0, 0);

    // Saturation on the 3-bit counter, then clear alongside stall.
    for (int i = 0; i < 10; i++) cyc(1, IALU, 1, 0, 0);
    cyc(1, IALU, 1, 0, 1);
    cyc(1, IALU, 1, 1, 0);

    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      cyc($urandom_range(0, 9) != 0, op, $urandom_range(0, 6) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
    end

    // Asynchronous reset between edges with the pipe full.
    for (int i = 0; i < 4; i++) cyc(1, ops[i], 0, 0, 0);
    cyc(1, LOAD, 1, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(posedge clk); #1;
    compare_all();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, LOAD, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/control_pipeline.md
# control_pipeline

Pipelined control unit for the 5-stage RISC-V core. Decodes the 7-bit opcode in ID and carries the resulting control bits through the ID/EX, EX/MEM and MEM/WB registers, so each stage sees its own copy. Adds to the single-stage decoder:
- U/J-type support (LUI, AUIPC, JAL, JALR);
- an illegal-opcode flag;
- branch flush;
- a saturating bubble counter for performance monitoring.

## Interface
Parameters:
- ALUOP_W, 2, width of ALU-op code; must be ≥2; bits above [1:0] always 0
- ENABLE_UJ, 1, 1 = decode LUI/AUIPC/JAL/JALR; 0 = treat them as illegal
- CNT_W, 16, width of bubble counter

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- opcode  in  7  instruction[6:0] in ID
- stall  in  1  load-use hazard; insert bubble into ID/EX
- flush  in  1  branch/jump taken in MEM; kill ID/EX and EX/MEM contents
- cnt_clr  in  1  synchronous clear of bubble_cnt
- ex_valid, ex_alusrc, ex_branch, ex_jump, ex_illegal  out  1 each  ID/EX fields
- ex_asel  out  2  ALU A source: 00 rs1, 01 PC, 10 zero
- ex_aluop  out  ALUOP_W  ALU-op code
- mem_valid, mem_memread, mem_memwrite, mem_branch, mem_jump  out  1 each  EX/MEM fields
- wb_valid, wb_regwrite  out  1 each  MEM/WB fields
- wb_sel  out  2  write-back source: 00 ALU, 01 memory, 10 PC+4
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted

## Operation
Decode (combinational, ID). Any field not listed is 0.
- 0000011 LOAD: alusrc=1, memread=1, regwrite=1, wb_sel=01, aluop=00
- 0100011 STORE: alusrc=1, memwrite=1, aluop=00
- 0110011 R-type: regwrite=1, aluop=10
- 0010011 I-ALU: alusrc=1, regwrite=1, aluop=11
- 1100011 BRANCH: branch=1, aluop=01
- 0110111 LUI: asel=10, alusrc=1, regwrite=1, aluop=00
- 0010111 AUIPC: asel=01, alusrc=1, regwrite=1, aluop=00
- 1101111 JAL: jump=1, regwrite=1, wb_sel=10
- 1100111 JALR: jump=1, alusrc=1, regwrite=1, wb_sel=10, aluop=00
- Any other opcode, or a U/J opcode with ENABLE_UJ=0: all zero except illegal=1.
- id_valid=0: the whole decode vector is zero, including illegal.

Register update (each rising edge):
- ID/EX:
  - flush=1: cleared.
  - else stall=1: cleared (bubble).
  - else: loads the decode vector, with valid=id_valid.
- EX/MEM:
  - flush=1: cleared.
  - else: loads from ID/EX (memread, memwrite, branch, jump, regwrite, wb_sel, valid).
- MEM/WB: always loads from EX/MEM. Flush does not affect it; the branch in MEM commits.
- stall does not hold EX/MEM or MEM/WB; they keep advancing.

Bubble counter:
- A bubble is an edge where ID/EX is cleared by stall or flush while id_valid=1.
- bubble_cnt increments by 1 on each bubble and saturates at 2^CNT_W−1 with no wrap.
- cnt_clr=1 zeroes it on the next edge and has priority over increment.

Fault and warning handling:
- ex_illegal is informational only. The instruction still flows with all write enables at 0, so it cannot corrupt architectural state.

## Timing
- Reset (rst_n=0, asynchronous): every output, all stage registers and bubble_cnt are 0 immediately, and stay 0 until the first edge after release.
- Latency: an opcode present in cycle N appears on ex_* in cycle N+1, on mem_* in N+2, and on wb_* in N+3.
- Fields within one stage always belong to the same instruction; no field is shared across stages.
- flush and stall together: flush wins. ID/EX and EX/MEM are cleared, and bubble_cnt increments once if id_valid=1.
- Flush on consecutive cycles: each edge clears the two registers again; MEM/WB drains normally.
- Reset asserted mid-stream: in-flight instructions are discarded with no partial update. bubble_cnt returns to 0.

## Test plan
- Reset then stream LOAD, STORE, R, I, BRANCH with id_valid=1 → one cycle later ex_aluop = 00, 00, 10, 11, 01. wb_sel=01 reaches wb_* only for LOAD, in cycle N+3.
- LOAD followed by stall=1 for 1 cycle on the dependent R-type → ex_valid=0 for one cycle. EX/MEM still shows the LOAD with mem_memread=1. bubble_cnt=1.
- BRANCH reaches MEM, flush=1 with JAL in ID and I-ALU in EX → next cycle ex_valid=0, mem_valid=0, and wb_* carries the BRANCH with wb_regwrite=0.
- ENABLE_UJ=0 build, opcode 1101111 → ex_illegal=1, ex_jump=0, and no write enable set in any stage. ENABLE_UJ=1 build: ex_jump=1 and wb_sel=10 three cycles later.
- CNT_W=3, hold stall=1 with id_valid=1 for 10 cycles → bubble_cnt reaches 7 and holds. cnt_clr=1 alongside stall → 0 on the next edge.
- Drop rst_n between edges while all stages are valid → all outputs 0 asynchronously. After release, with id_valid=0, all outputs stay 0.
